// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: rips the carry through WIDTH/CHUNK chunks, one
// chunk per clock, between a valid/ready producer and consumer.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  a_ch;
    logic [CHUNK-1:0]  b_ch;
    logic [CHUNK-1:0]  s_ch;
    logic              c_ch;
    logic              last;
    logic              accept;
    logic              ovf_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == IDXW'(NCH - 1));

    // Operand chunk select; op_b is already inverted for subtraction.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == IDXW'(k)) begin
                a_ch = op_a[k*CHUNK +: CHUNK];
                b_ch = op_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};

    // Signed overflow: operand signs agree but the result sign differs.
    assign ovf_nxt = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (s_ch[CHUNK-1] != op_a[WIDTH-1]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a  <= a;
                op_b  <= b ^ {WIDTH{sub}};
                carry <= sub | cin;
                idx   <= '0;
                sum   <= '0;
            end else if (state == RUN) begin
                for (int k = 0; k < NCH; k++) begin
                    if (idx == IDXW'(k)) sum[k*CHUNK +: CHUNK] <= s_ch;
                end
                carry <= c_ch;
                idx   <= idx + IDXW'(1);
                if (last) begin
                    cout <= c_ch;
                    ovf  <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three instances (CHUNK=1,4,16) share stimulus and are
// checked every cycle against a plain-arithmetic model of add/sub.
module tb_chunked_adder;

    localparam int W  = 16;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic cin = 1'b0;
    logic sub = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [ND-1:0]        in_ready;
    logic [ND-1:0]        out_valid;
    logic [ND-1:0]        cout;
    logic [ND-1:0]        ovf;
    logic [ND-1:0][W-1:0] sum;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_acc = 0;
    bit active = 1'b0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        chunked_adder #(.WIDTH(W), .CHUNK(g == 0 ? 1 : (g == 1 ? 4 : 16))) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .sum(sum[g]), .cout(cout[g]), .ovf(ovf[g])
        );
    end

    function automatic int nch(input int d);
        return (d == 0) ? 16 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: unsigned sum/difference and true signed range check.
    task automatic set_model(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic s);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            exp_sum  = x - y;
            exp_cout = (x >= y);
            r = sx - sy;
        end else begin
            {exp_cout, exp_sum} = {1'b0, x} + {1'b0, y} + {16'd0, ci};
            r = sx + sy + (ci ? 1 : 0);
        end
        exp_ovf = (r > 32767) || (r < -32768);
    endtask

    always @(negedge clk) begin
        if (active) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("in_ready_busy[%0d]", d), in_ready[d], 0);
                chk($sformatf("out_valid[%0d] age %0d", d, cyc - t_acc), out_valid[d],
                    (cyc - t_acc) >= nch(d));
                if (out_valid[d]) begin
                    chk($sformatf("sum[%0d]", d), sum[d], exp_sum);
                    chk($sformatf("cout[%0d]", d), cout[d], exp_cout);
                    chk($sformatf("ovf[%0d]", d), ovf[d], exp_ovf);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic s, input int hold, input bit lit_en,
                          input logic [W-1:0] lsum, input logic lcout, input logic lovf);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        set_model(x, y, ci, s);
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_acc = cyc;
        active = 1'b1;
        // Scramble inputs and pulse in_valid while busy: must not disturb anything.
        repeat (16 + hold) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if (lit_en) begin
            chk("lit_sum", sum[1], lsum);
            chk("lit_cout", cout[1], lcout);
            chk("lit_ovf", ovf[1], lovf);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        active = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("in_ready_after[%0d]", d), in_ready[d], 1);
            chk($sformatf("out_valid_after[%0d]", d), out_valid[d], 0);
        end
    endtask

    initial begin
        logic [W-1:0] x, y;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1);
            chk($sformatf("rst_out_valid[%0d]", d), out_valid[d], 0);
            chk($sformatf("rst_sum[%0d]", d), sum[d], 0);
            chk($sformatf("rst_cout[%0d]", d), cout[d], 0);
            chk($sformatf("rst_ovf[%0d]", d), ovf[d], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h0FCD, 1'b1, 1'b0, 0, 1'b1, 16'h2202, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op(16'hABCD, 16'h1357, 1'b0, 1'b0, 10, 1'b0, '0, 1'b0, 1'b0);

        // Abort: reset sampled at the end of the second RUN cycle.
        a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("abort_in_ready[%0d]", d), in_ready[d], 1);
            chk($sformatf("abort_sum[%0d]", d), sum[d], 0);
        end
        repeat (20) begin
            chk("abort_no_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            case ($urandom_range(0, 5))
                0: x = 16'h7FFF;
                1: x = 16'h8000;
                2: y = 16'hFFFF;
                3: y = x;
                default: ;
            endcase
            run_op(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b0, '0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
